// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl: port-mapped interrupt controller for the RAT MCU.
// Collects up to eight rising-edge sources, latches them as pending,
// masks them, and services the lowest pending index with a one-cycle
// INTERRUPT pulse, then waits for a software ACK and a short holdoff.
//
// Ports:
//   i_clk       MCU clock, all state changes on the rising edge
//   i_reset     synchronous, active-high reset
//   i_irq_in    interrupt source lines (NUM_SRC wide)
//   i_port_id   MCU port ID
//   i_out_port  MCU write data
//   i_io_strb   MCU write strobe
//   o_rd_data   combinational read data, 0 for foreign port IDs
//   o_interrupt one-cycle interrupt pulse to the MCU
//
// Optional feature: define INTC_ACK_TIMEOUT_EN to build the ACK
// timeout counter and the sticky timeout flag (vector bit 7).

module rat_int_ctrl #(
    parameter int unsigned NUM_SRC     = 8,
    parameter logic [7:0]  MASK_ID     = 8'h60,
    parameter logic [7:0]  STATUS_ID   = 8'h61,
    parameter logic [7:0]  VECTOR_ID   = 8'h62,
    parameter logic [7:0]  ACK_ID      = 8'h63,
    parameter int unsigned HOLDOFF_CYC = 4
`ifdef INTC_ACK_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SRC-1:0] i_irq_in,
    input  logic [7:0]         i_port_id,
    input  logic [7:0]         i_out_port,
    input  logic               i_io_strb,
    output logic [7:0]         o_rd_data,
    output logic               o_interrupt
);

    // Internal source vectors are always 8 bits; bits at or above
    // NUM_SRC are held at zero by this mask.
    localparam logic [7:0] SRC_MSK = 8'((9'd1 << NUM_SRC) - 9'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_ACK,
        S_HOLDOFF
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_prev;
    logic [7:0] r_pending;
    logic [7:0] r_mask;
    logic [7:0] r_hold_cnt;
    logic [2:0] r_vec;

    logic [7:0] w_irq;
    logic [7:0] w_rise;
    logic [7:0] w_elig;
    logic [7:0] w_vec_oh;
    logic [7:0] w_stat_clr;
    logic [7:0] w_clr;
    logic [2:0] w_win;
    logic       w_wr_mask;
    logic       w_wr_status;
    logic       w_wr_ack;
    logic       w_ack_ok;
    logic       w_active;
    logic       w_timeout;
    logic       w_to_flag;

    assign w_irq       = 8'(i_irq_in);
    assign w_rise      = w_irq & ~r_prev;
    assign w_elig      = r_pending & r_mask;
    assign w_vec_oh    = 8'h01 << r_vec;

    assign w_wr_mask   = i_io_strb && (i_port_id == MASK_ID);
    assign w_wr_status = i_io_strb && (i_port_id == STATUS_ID);
    assign w_wr_ack    = i_io_strb && (i_port_id == ACK_ID);

    // The source being serviced is protected from status-register clears;
    // only its ACK retires it.
    assign w_stat_clr  = w_wr_status
                       ? (i_out_port & ~(w_active ? w_vec_oh : 8'h00))
                       : 8'h00;
    assign w_clr       = w_stat_clr | (w_ack_ok ? w_vec_oh : 8'h00);

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_elig[i]) w_win = 3'(i);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ack_ok    = 1'b0;
        w_active    = 1'b0;
        o_interrupt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|w_elig) w_next = S_FIRE;
            end
            S_FIRE: begin
                w_active    = 1'b1;
                o_interrupt = ~i_reset;
                w_next      = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                w_active = 1'b1;
                if (w_wr_ack) begin
                    w_ack_ok = 1'b1;
                    w_next   = S_HOLDOFF;
                end else if (w_timeout) begin
                    w_next = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (r_hold_cnt == 8'd0) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        // prev tracks the lines even in reset so a line already high
        // does not look like a fresh edge afterwards.
        r_prev <= w_irq;
        if (i_reset) begin
            r_pending  <= 8'h00;
            r_mask     <= 8'h00;
            r_vec      <= 3'd0;
            r_hold_cnt <= 8'd0;
        end else begin
            // Set wins over a same-edge clear.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_wr_mask) r_mask <= i_out_port & SRC_MSK;
            if (r_state == S_IDLE && (|w_elig)) r_vec <= w_win;
            if (r_state == S_WAIT_ACK && w_next == S_HOLDOFF)
                r_hold_cnt <= 8'(HOLDOFF_CYC - 1);
            else if (r_state == S_HOLDOFF && r_hold_cnt != 8'd0)
                r_hold_cnt <= r_hold_cnt - 8'd1;
        end
    end

`ifdef INTC_ACK_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_to_flag;

    assign w_timeout = (r_to_cnt == 8'(TIMEOUT_CYC - 1));
    assign w_to_flag = r_to_flag;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_to_cnt  <= 8'd0;
            r_to_flag <= 1'b0;
        end else begin
            if (r_state == S_FIRE)
                r_to_cnt <= 8'd0;
            else if (r_state == S_WAIT_ACK)
                r_to_cnt <= r_to_cnt + 8'd1;
            // A timeout leaves pending[vec] set so the source is retried.
            if (w_ack_ok)
                r_to_flag <= 1'b0;
            else if (r_state == S_WAIT_ACK && w_timeout)
                r_to_flag <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_to_flag = 1'b0;
`endif

    always_comb begin
        o_rd_data = 8'h00;
        case (i_port_id)
            MASK_ID:   o_rd_data = r_mask;
            STATUS_ID: o_rd_data = r_pending;
            VECTOR_ID: o_rd_data = {w_to_flag, w_active, 3'b000, r_vec};
            default:   o_rd_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// tb_rat_int_ctrl: directed bench for rat_int_ctrl with a timeline model
// checked every cycle plus hand-computed literal expectations.

module tb_rat_int_ctrl;

    localparam logic [7:0] MASK_ID   = 8'h60;
    localparam logic [7:0] STATUS_ID = 8'h61;
    localparam logic [7:0] VECTOR_ID = 8'h62;
    localparam logic [7:0] ACK_ID    = 8'h63;
    localparam int         HC        = 4;
`ifdef INTC_ACK_TIMEOUT_EN
    localparam int         TO        = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic [7:0] pid;
    logic [7:0] odata;
    logic       strb;
    logic [7:0] rd;
    logic       intr;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    rat_int_ctrl #(
        .HOLDOFF_CYC(HC)
`ifdef INTC_ACK_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TO)
`endif
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_irq_in   (irq),
        .i_port_id  (pid),
        .i_out_port (odata),
        .i_io_strb  (strb),
        .o_rd_data  (rd),
        .o_interrupt(intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Timeline model: a service is either in progress (cur >= 0, fired at
    // edge fire_at) or the next one may start at edge free_at or later.
    logic [7:0] mp, mm, mprev;
    logic [2:0] mvec;
    logic       mflag;
    int         cur, fire_at, free_at, cyc;
    bit         mvalid = 1'b0;

    initial cyc = 0;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] p);
        case (p)
            MASK_ID:   return mm;
            STATUS_ID: return mp;
            VECTOR_ID: return {mflag, (cur >= 0), 3'b000, mvec};
            default:   return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] p0, rise, clr, elig, own;
        bit         busy, ack;
        cyc++;
        if (rst) begin
            mp      = 8'h00;
            mm      = 8'h00;
            mprev   = irq;
            mvec    = 3'd0;
            mflag   = 1'b0;
            cur     = -1;
            fire_at = -100;
            free_at = 0;
            mvalid  = 1'b1;
        end else begin
            p0    = mp;
            elig  = mp & mm;
            busy  = (cur >= 0);
            rise  = irq & ~mprev;
            mprev = irq;
            clr   = 8'h00;
            own   = busy ? (8'h01 << cur) : 8'h00;
            ack   = strb && pid == ACK_ID && busy && cyc >= fire_at + 2;
            if (strb && pid == STATUS_ID) clr = clr | (odata & ~own);
            if (ack) begin
                clr     = clr | own;
                cur     = -1;
                mflag   = 1'b0;
                free_at = cyc + HC + 1;
            end
`ifdef INTC_ACK_TIMEOUT_EN
            else if (busy && cyc == fire_at + 1 + TO) begin
                cur     = -1;
                mflag   = 1'b1;
                free_at = cyc + HC + 1;
            end
`endif
            if (!busy && cyc >= free_at && elig != 8'h00) begin
                cur     = lowest(elig);
                mvec    = 3'(cur);
                fire_at = cyc;
            end
            mp = (p0 & ~clr) | rise;
            if (strb && pid == MASK_ID) mm = odata;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_int", {7'b0, intr},
                {7'b0, (cur >= 0 && cyc == fire_at && !rst)});
            chk("model_rd", rd, m_read(pid));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        pid   = p;
        odata = d;
        strb  = 1'b1;
        tick(1);
        strb  = 1'b0;
        pid   = 8'h00;
        odata = 8'h00;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] p,
                          input logic [7:0] exp);
        pid = p;
        #1;
        chk(nm, rd, exp);
    endtask

    task automatic int_chk(input string nm, input logic exp);
        chk(nm, {7'b0, intr}, {7'b0, exp});
    endtask

    initial begin
        rst   = 1'b1;
        irq   = 8'h00;
        pid   = 8'h00;
        odata = 8'h00;
        strb  = 1'b0;
        tick(3);
        rst = 1'b0;
        rd_chk("rst_mask", MASK_ID, 8'h00);
        rd_chk("rst_status", STATUS_ID, 8'h00);
        rd_chk("rst_vector", VECTOR_ID, 8'h00);
        int_chk("rst_int", 1'b0);

        // basic pulse
        wr(MASK_ID, 8'h01);
        irq = 8'h01;
        tick(1);
        int_chk("basic_n1_int", 1'b0);
        rd_chk("basic_pend", STATUS_ID, 8'h01);
        tick(1);
        int_chk("basic_pulse", 1'b1);
        rd_chk("basic_vec", VECTOR_ID, 8'h40);
        tick(1);
        int_chk("basic_one_cycle", 1'b0);
        wr(ACK_ID, 8'h00);
        rd_chk("basic_ack_status", STATUS_ID, 8'h00);
        rd_chk("basic_hold_vec", VECTOR_ID, 8'h00);
        irq = 8'h00;
        tick(6);

        // priority
        wr(MASK_ID, 8'hFF);
        irq = 8'h24;
        tick(1);
        rd_chk("prio_pend", STATUS_ID, 8'h24);
        tick(1);
        int_chk("prio_pulse1", 1'b1);
        rd_chk("prio_vec1", VECTOR_ID, 8'h42);
        tick(1);
        wr(ACK_ID, 8'h00);
        rd_chk("prio_hold_vec", VECTOR_ID, 8'h02);
        rd_chk("prio_status", STATUS_ID, 8'h20);
        tick(4);
        int_chk("prio_holdoff", 1'b0);
        tick(1);
        int_chk("prio_pulse2", 1'b1);
        rd_chk("prio_vec2", VECTOR_ID, 8'h45);
        rd_chk("prio_status2", STATUS_ID, 8'h20);
        tick(1);
        wr(ACK_ID, 8'h00);
        rd_chk("prio_done", STATUS_ID, 8'h00);
        irq = 8'h00;
        tick(6);

        // masking
        wr(MASK_ID, 8'h00);
        irq = 8'h08;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            int_chk("mask_nopulse", 1'b0);
        end
        rd_chk("mask_pend", STATUS_ID, 8'h08);
        wr(MASK_ID, 8'h08);
        int_chk("mask_wr_edge", 1'b0);
        tick(1);
        int_chk("mask_pulse", 1'b1);
        rd_chk("mask_vec", VECTOR_ID, 8'h43);
        tick(1);
        wr(ACK_ID, 8'h00);
        irq = 8'h00;
        tick(6);

        // same-edge set and clear
        wr(MASK_ID, 8'h02);
        irq = 8'h02;
        tick(2);
        int_chk("sc_pulse1", 1'b1);
        rd_chk("sc_vec1", VECTOR_ID, 8'h41);
        tick(1);
        irq = 8'h00;
        tick(1);
        irq = 8'h02;
        wr(ACK_ID, 8'h00);
        rd_chk("sc_status", STATUS_ID, 8'h02);
        rd_chk("sc_hold_vec", VECTOR_ID, 8'h01);
        tick(4);
        int_chk("sc_holdoff", 1'b0);
        tick(1);
        int_chk("sc_pulse2", 1'b1);
        tick(1);
        wr(ACK_ID, 8'h00);
        irq = 8'h00;
        tick(6);

        // reset mid-sequence with lines held high
        wr(MASK_ID, 8'h01);
        irq = 8'hFF;
        tick(2);
        int_chk("rs_pulse", 1'b1);
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        rd_chk("rs_mask", MASK_ID, 8'h00);
        rd_chk("rs_status", STATUS_ID, 8'h00);
        rd_chk("rs_vector", VECTOR_ID, 8'h00);
        wr(MASK_ID, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            int_chk("rs_nopulse", 1'b0);
        end
        rd_chk("rs_status_after", STATUS_ID, 8'h00);
        irq = 8'h00;
        tick(2);

`ifdef INTC_ACK_TIMEOUT_EN
        // ACK timeout and retry
        wr(MASK_ID, 8'h01);
        irq = 8'h01;
        tick(2);
        int_chk("to_pulse", 1'b1);
        tick(10);
        rd_chk("to_waiting", VECTOR_ID, 8'h40);
        tick(1);
        rd_chk("to_flag", VECTOR_ID, 8'h80);
        rd_chk("to_pend", STATUS_ID, 8'h01);
        tick(5);
        int_chk("to_repulse", 1'b1);
        rd_chk("to_vec", VECTOR_ID, 8'hC0);
        tick(1);
        wr(ACK_ID, 8'h00);
        rd_chk("to_cleared", VECTOR_ID, 8'h00);
        irq = 8'h00;
        tick(6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
